cpu_core_mc: RTL and testbench
==============================

Name: cpu_core_mc

Overview:
- Parametrised multi-cycle successor to the 4-bit single-cycle CPU.
- Data width, register count and PC width are generic. Fetch and data memory use valid/ack handshakes, so ROM and RAM may take wait states.
- Adds real unsigned LT, branch on register condition, HALT, memory-mapped GPO and a per-instruction retire pulse.
- Sits between the instruction ROM loader and the data RAM in the tiny SoC.

Parameters:
- DW, 4: data/register width (>=4).
- RA, 3: register address bits; register file has 2**RA entries.
- PCW, 3: program counter width. Instruction memory depth is 2**PCW.
- IW, 3*RA+6: derived instruction width; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; sampled only in FETCH.
- i_addr  out  PCW  instruction address (= pc).
- i_data  in  IW  instruction word.
- i_valid  in  1  i_data valid for current i_addr.
- d_req  out  1  data request; held high until d_ack.
- d_we  out  1  1 = store, 0 = load; valid while d_req=1.
- d_addr  out  DW-1  data address = R[rs1][DW-2:0].
- d_wdata  out  DW  store data = R[rs2].
- d_rdata  in  DW  load data; valid when d_ack=1.
- d_ack  in  1  completes the request in the same cycle.
- gpo  out  DW  general-purpose output register.
- halted  out  1  core is in HALT.
- retired  out  1  one-cycle pulse per completed instruction.

Behaviour:
- Instruction format, MSB to LSB: type[3], rd[RA], rs2[RA], rs1[RA], func[3].
- Immediate = {rs1 field, func}, zero-extended or truncated to DW.
- Reset (async assert, sync release):
  - pc=0, state=FETCH, all registers=0, gpo=0.
  - d_req=0, d_we=0, halted=0, retired=0.
  - Reset during MEM drops d_req at once. A later d_ack is ignored unless a new request is outstanding.
- State FETCH:
  - i_addr=pc.
  - If en=1 and i_valid=1: latch i_data into ir, go to EXEC.
  - Otherwise stay; en=0 is a clean stall here only.
- State EXEC, by type:
  - ALU (000): rd <= f(R[rs1],R[rs2]); pc+1; FETCH; retired=1.
  - LOAD (001): go to MEM with d_req=1, d_we=0.
  - STORE (010), R[rs1][DW-1]=1: gpo <= R[rs2]; no request; pc+1; FETCH; retired=1.
  - STORE (010), R[rs1][DW-1]=0: go to MEM with d_req=1, d_we=1.
  - IMM (011): rd <= immediate; pc+1; FETCH; retired=1.
  - JUMP (100): pc <= R[rs1] (truncate or zero-extend to PCW); FETCH; retired=1.
  - CJUMP (101): if R[rs2][0]=1, pc <= R[rs1]; else pc+1. Then FETCH; retired=1.
  - HALT (110): go to HALT; retired=1.
  - Type 111: NOP; pc+1; FETCH; retired=1.
- State MEM:
  - d_req, d_we, d_addr and d_wdata are stable from ir and the register file until the d_ack cycle.
  - On d_ack: a load writes rd <= d_rdata. pc+1, d_req=0 next cycle, FETCH, retired=1.
  - en is ignored in MEM; in-flight instructions always complete.
- State HALT:
  - halted=1, pc frozen, no requests.
  - Exit only via reset.
- ALU func:
  - 000 add, modulo 2**DW.
  - 001 and; 010 or; 011 xor.
  - 100 not R[rs1].
  - 101 eq: result is 1 or 0, zero-extended.
  - 110 unsigned lt: result is 1 or 0, zero-extended.
  - 111 shift left 1, zero fill, MSB discarded.
- PC wraps modulo 2**PCW; 2**PCW-1 is followed by 0.
- rd=rs1 or rd=rs2: the read uses the pre-write value. The write lands at the clock edge ending EXEC (or MEM).
- Latency:
  - Minimum 2 cycles per non-memory instruction.
  - Memory instruction = 3 cycles plus d_ack wait cycles.
  - retired asserts in the final cycle of each instruction.

Test Plan:
- Reset + IMM, zero-wait ROM, DW=4: run IMM r1,5; IMM r2,3; ALU add r3=r1+r2; store r3 to GPO address 8. Require gpo=8, retired pulsing every 2 cycles, gpo=0 before the store.
- ALU sweep: r1=9, r2=12 through all 8 funcs. Require add=5, and=8, or=13, xor=5, not=6, eq=0, lt=1, shl=2.
- Wait-state RAM: store 7 to address 2, then load from address 2 into r4, with d_ack delayed 3 cycles. Require d_req held and d_addr/d_wdata stable for 4 cycles, r4=7, no retired pulse until the ack.
- Branch/wrap, PCW=3: CJUMP with R[rs2]=0 at pc=7 gives pc=0. CJUMP with R[rs2]=1 and R[rs1]=5 gives pc=5. JUMP with R[rs1]=0xE gives pc=6.
- Stall/halt: en=0 in FETCH holds pc and produces no retire. en dropped during MEM still completes the load. After HALT, halted=1, i_addr is constant and d_req=0 for 20 cycles.
- Async reset mid-MEM: assert rst_n=0 between clock edges while d_req=1. Require d_req=0 and pc=0 immediately. A late d_ack is ignored, and the core fetches from 0 after release.

Source files
------------

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: parametrised multi-cycle core with handshaked fetch
// and data ports, memory-mapped GPO, HALT state and retire pulse.
module cpu_core_mc #(
  parameter int DW  = 4,
  parameter int RA  = 3,
  parameter int PCW = 3,
  parameter int IW  = 3*RA+6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [PCW-1:0] i_addr,
  input  logic [IW-1:0] i_data,
  input  logic          i_valid,
  output logic          d_req,
  output logic          d_we,
  output logic [DW-2:0] d_addr,
  output logic [DW-1:0] d_wdata,
  input  logic [DW-1:0] d_rdata,
  input  logic          d_ack,
  output logic [DW-1:0] gpo,
  output logic          halted,
  output logic          retired
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [2:0] T_ALU   = 3'd0;
  localparam logic [2:0] T_LOAD  = 3'd1;
  localparam logic [2:0] T_STORE = 3'd2;
  localparam logic [2:0] T_IMM   = 3'd3;
  localparam logic [2:0] T_JUMP  = 3'd4;
  localparam logic [2:0] T_CJUMP = 3'd5;
  localparam logic [2:0] T_HALT  = 3'd6;

  logic [1:0]     state;
  logic [PCW-1:0] pc;
  logic [IW-1:0]  ir;
  logic [DW-1:0]  rf [2**RA];

  logic [2:0]    op;
  logic [RA-1:0] rd;
  logic [RA-1:0] rs2;
  logic [RA-1:0] rs1;
  logic [2:0]    fn;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] imm;
  logic [DW-1:0] alu;
  logic          mem_op;
  logic          rf_we;
  logic [DW-1:0] rf_wd;

  assign op  = ir[3*RA+5 -: 3];
  assign rd  = ir[3*RA+2 -: RA];
  assign rs2 = ir[2*RA+2 -: RA];
  assign rs1 = ir[RA+2 -: RA];
  assign fn  = ir[2:0];
  assign a   = rf[rs1];
  assign b   = rf[rs2];
  assign imm = DW'({rs1, fn});

  // Loads and non-GPO stores need the MEM state
  assign mem_op = (op == T_LOAD) ||
                  (op == T_STORE && !a[DW-1]);

  assign i_addr  = pc;
  assign d_req   = (state == S_MEM);
  assign d_we    = d_req && (op == T_STORE);
  assign d_addr  = a[DW-2:0];
  assign d_wdata = b;
  assign halted  = (state == S_HALT);
  assign retired = (state == S_EXEC && !mem_op) ||
                   (state == S_MEM && d_ack);

  // ALU function select
  always_comb begin
    alu = '0;
    unique case (fn)
      3'd0: alu = a + b;
      3'd1: alu = a & b;
      3'd2: alu = a | b;
      3'd3: alu = a ^ b;
      3'd4: alu = ~a;
      3'd5: alu = DW'(a == b);
      3'd6: alu = DW'(a < b);
      3'd7: alu = {a[DW-2:0], 1'b0};
    endcase
  end

  // Register write port source and enable
  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu;
    if (state == S_EXEC && op == T_ALU) begin
      rf_we = 1'b1;
    end else if (state == S_EXEC && op == T_IMM) begin
      rf_we = 1'b1;
      rf_wd = imm;
    end else if (state == S_MEM && d_ack && op == T_LOAD) begin
      rf_we = 1'b1;
      rf_wd = d_rdata;
    end
  end

  // Register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**RA; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[rd] <= rf_wd;
    end
  end

  // Sequencer: fetch, execute, memory wait, halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      gpo   <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (en && i_valid) begin
            ir    <= i_data;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (op)
            T_LOAD:  state <= S_MEM;
            T_STORE: begin
              if (a[DW-1]) begin
                gpo <= b;
                pc  <= pc + PCW'(1);
              end else begin
                state <= S_MEM;
              end
            end
            T_JUMP:  pc <= PCW'(a);
            T_CJUMP: pc <= b[0] ? PCW'(a) : pc + PCW'(1);
            T_HALT:  state <= S_HALT;
            default: pc <= pc + PCW'(1);
          endcase
        end
        S_MEM: begin
          if (d_ack) begin
            pc    <= pc + PCW'(1);
            state <= S_FETCH;
          end
        end
        S_HALT: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_mc.sv
// tb_cpu_core_mc: directed vectors for cpu_core_mc with a
// behavioural ROM and a wait-state RAM responder.
module tb_cpu_core_mc;

  localparam int DW  = 4;
  localparam int RA  = 3;
  localparam int PCW = 3;
  localparam int IW  = 3*RA+6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           iv = 1'b1;
  logic [PCW-1:0] i_addr;
  logic [IW-1:0]  i_data;
  logic           d_req;
  logic           d_we;
  logic [DW-2:0]  d_addr;
  logic [DW-1:0]  d_wdata;
  logic [DW-1:0]  rdata_q = '0;
  logic           d_ack;
  logic           ram_ack = 1'b0;
  logic           man_ack = 1'b0;
  logic           ram_on = 1'b1;
  int             ack_wait = 0;
  int             cnt = 0;
  logic [DW-1:0]  gpo;
  logic           halted;
  logic           retired;

  logic [IW-1:0]  rom [8];
  logic [DW-1:0]  mem [8];

  int n_chk = 0;
  int n_fail = 0;

  assign i_data = rom[i_addr];
  assign d_ack  = ram_ack | man_ack;

  cpu_core_mc #(.DW(DW), .RA(RA), .PCW(PCW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .i_addr  (i_addr),
    .i_data  (i_data),
    .i_valid (iv),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (rdata_q),
    .d_ack   (d_ack),
    .gpo     (gpo),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  // RAM: acks after ack_wait extra cycles of d_req
  always @(posedge clk) begin
    #2;
    if (d_req && ram_on) begin
      if (cnt >= ack_wait) begin
        ram_ack = 1'b1;
        cnt = 0;
        if (d_we) mem[d_addr] = d_wdata;
        else rdata_q = mem[d_addr];
      end else begin
        ram_ack = 1'b0;
        cnt++;
      end
    end else begin
      ram_ack = 1'b0;
      cnt = 0;
    end
  end

  typedef struct {
    logic [2:0] fn;
    logic [3:0] exp;
    string      nm;
  } alu_vec_t;

  alu_vec_t vt[8];
  int       seq[10];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc(input logic [2:0] t,
      input logic [2:0] rd, input logic [2:0] rs2,
      input logic [2:0] rs1, input logic [2:0] fn);
    return {t, rd, rs2, rs1, fn};
  endfunction

  function automatic logic [IW-1:0] imm(input logic [2:0] rd,
                                        input logic [5:0] v);
    return enc(3'd3, rd, 3'd0, v[5:3], v[2:0]);
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = enc(3'd6, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_halt(input string nm);
    int k;
    k = 0;
    en = 1'b1;
    while (!halted && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({nm, " halt reached"}, 32'(halted), 1);
  endtask

  task automatic wait_req(input string nm);
    int k;
    k = 0;
    while (!d_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({nm, " req seen"}, 32'(d_req), 1);
  endtask

  initial begin
    vt[0] = '{3'd0, 4'd5,  "add"};
    vt[1] = '{3'd1, 4'd8,  "and"};
    vt[2] = '{3'd2, 4'd13, "or"};
    vt[3] = '{3'd3, 4'd5,  "xor"};
    vt[4] = '{3'd4, 4'd6,  "not"};
    vt[5] = '{3'd5, 4'd0,  "eq"};
    vt[6] = '{3'd6, 4'd1,  "lt"};
    vt[7] = '{3'd7, 4'd2,  "shl"};
    seq = '{0, 1, 2, 3, 6, 5, 6, 7, 0, 1};

    // Reset state, then IMM/ALU/GPO store with zero-wait ROM
    clear_rom();
    rom[0] = imm(3'd1, 6'd5);
    rom[1] = imm(3'd2, 6'd3);
    rom[2] = enc(3'd0, 3'd3, 3'd2, 3'd1, 3'd0);
    rom[3] = imm(3'd4, 6'd8);
    rom[4] = enc(3'd2, 3'd0, 3'd3, 3'd4, 3'd0);
    rst_n = 1'b0;
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst i_addr", 32'(i_addr), 0);
    check("rst d_req", 32'(d_req), 0);
    check("rst d_we", 32'(d_we), 0);
    check("rst halted", 32'(halted), 0);
    check("rst retired", 32'(retired), 0);
    check("rst gpo", 32'(gpo), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("t1 retired c%0d", k), 32'(retired),
            32'(k % 2 == 0));
      if (k == 8) check("t1 gpo before store", 32'(gpo), 0);
      if (k == 9) check("t1 gpo after store", 32'(gpo), 8);
    end
    run_halt("t1");
    check("t1 halt pc", 32'(i_addr), 5);

    // ALU sweep, r1=9 r2=12
    for (int v = 0; v < 8; v++) begin
      clear_rom();
      rom[0] = imm(3'd1, 6'd9);
      rom[1] = imm(3'd2, 6'd12);
      rom[2] = imm(3'd5, 6'd8);
      rom[3] = enc(3'd0, 3'd3, 3'd2, 3'd1, vt[v].fn);
      rom[4] = enc(3'd2, 3'd0, 3'd3, 3'd5, 3'd0);
      do_reset();
      run_halt(vt[v].nm);
      check({"alu ", vt[v].nm}, 32'(gpo), 32'(vt[v].exp));
    end

    // Wait-state RAM store/load, en dropped in MEM, halt hold
    clear_rom();
    rom[0] = imm(3'd1, 6'd2);
    rom[1] = imm(3'd2, 6'd7);
    rom[2] = enc(3'd2, 3'd0, 3'd2, 3'd1, 3'd0);
    rom[3] = enc(3'd1, 3'd4, 3'd0, 3'd1, 3'd0);
    rom[4] = imm(3'd5, 6'd8);
    rom[5] = enc(3'd2, 3'd0, 3'd4, 3'd5, 3'd0);
    ack_wait = 3;
    do_reset();
    en = 1'b1;
    wait_req("st");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("st d_req c%0d", i), 32'(d_req), 1);
      check($sformatf("st d_we c%0d", i), 32'(d_we), 1);
      check($sformatf("st d_addr c%0d", i), 32'(d_addr), 2);
      check($sformatf("st d_wdata c%0d", i), 32'(d_wdata), 7);
      check($sformatf("st retired c%0d", i), 32'(retired),
            32'(i == 3));
      @(negedge clk);
    end
    check("st req dropped", 32'(d_req), 0);
    wait_req("ld");
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ld d_req c%0d", i), 32'(d_req), 1);
      check($sformatf("ld d_we c%0d", i), 32'(d_we), 0);
      check($sformatf("ld d_addr c%0d", i), 32'(d_addr), 2);
      check($sformatf("ld retired c%0d", i), 32'(retired),
            32'(i == 3));
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall pc c%0d", i), 32'(i_addr), 4);
      check($sformatf("stall retired c%0d", i), 32'(retired), 0);
      @(negedge clk);
    end
    run_halt("ld");
    check("ld gpo", 32'(gpo), 7);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt hold c%0d", i),
            32'({halted, d_req, i_addr}), 32'({1'b1, 1'b0, 3'd6}));
      @(negedge clk);
    end
    ack_wait = 0;

    // JUMP truncation, taken CJUMP, untaken CJUMP wrap at pc=7
    clear_rom();
    rom[0] = imm(3'd1, 6'd5);
    rom[1] = imm(3'd2, 6'd1);
    rom[2] = imm(3'd3, 6'd14);
    rom[3] = enc(3'd4, 3'd0, 3'd0, 3'd3, 3'd0);
    rom[5] = imm(3'd2, 6'd0);
    rom[6] = enc(3'd5, 3'd0, 3'd2, 3'd1, 3'd0);
    rom[7] = enc(3'd5, 3'd0, 3'd4, 3'd1, 3'd0);
    do_reset();
    en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      check($sformatf("br fetch %0d", j), 32'(i_addr), 32'(seq[j]));
      @(negedge clk);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a load
    clear_rom();
    rom[0] = imm(3'd1, 6'd2);
    rom[1] = enc(3'd1, 3'd4, 3'd0, 3'd1, 3'd0);
    rom[2] = imm(3'd5, 6'd8);
    rom[3] = enc(3'd2, 3'd0, 3'd4, 3'd5, 3'd0);
    ram_on = 1'b0;
    do_reset();
    en = 1'b1;
    wait_req("ar");
    #3;
    rst_n = 1'b0;
    #1;
    check("ar d_req", 32'(d_req), 0);
    check("ar i_addr", 32'(i_addr), 0);
    check("ar d_we", 32'(d_we), 0);
    en = 1'b0;
    man_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("ar late ack c%0d", i),
            32'({i_addr, retired, d_req}), 0);
    end
    man_ack = 1'b0;
    ram_on = 1'b1;
    en = 1'b1;
    @(negedge clk);
    check("ar refetch retired", 32'(retired), 1);
    @(negedge clk);
    check("ar next fetch", 32'(i_addr), 1);
    run_halt("ar");
    check("ar gpo", 32'(gpo), 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
